// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter + BTB predictor: zero-latency combinational lookup, training on the clock edge, no backpressure.
// Define BP_STATS_EN to build the resolved-branch and mispredict counters; otherwise both stat outputs read 0.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] F_pc,
  output logic            F_BP_taken,
  output logic [XLEN-1:0] F_BP_target,
  input  logic            EX_upd,
  input  logic [XLEN-1:0] EX_pc,
  input  logic            EX_true_taken,
  input  logic [XLEN-1:0] EX_target,
  input  logic            EX_BP_taken,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];

  logic [IDXW-1:0] f_idx;
  logic [TAGW-1:0] f_tag;
  logic            f_hit;
  logic [IDXW-1:0] ex_idx;
  logic [TAGW-1:0] ex_tag;
  logic            ex_hit;

  assign f_idx  = F_pc[IDXW-1:0];
  assign f_tag  = F_pc[XLEN-1:IDXW];
  assign ex_idx = EX_pc[IDXW-1:0];
  assign ex_tag = EX_pc[XLEN-1:IDXW];

  // Lookup reads only registered state, so an update in flight is not visible until the next cycle.
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign F_BP_taken  = f_hit && ctr_q[f_idx][1];
  assign F_BP_target = F_BP_taken ? target_q[f_idx] : F_pc + XLEN'(1);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= 2'b01;
        target_q[i] <= '0;
      end
    end else if (EX_upd) begin
      if (ex_hit) begin
        if (EX_true_taken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
          target_q[ex_idx] <= EX_target;
        end else if (ctr_q[ex_idx] != 2'b00) begin
          ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
        end
      end else if (EX_true_taken) begin
        // Allocation evicts whatever aliased entry held this index.
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        ctr_q[ex_idx]    <= 2'b10;
        target_q[ex_idx] <= EX_target;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (EX_upd) begin
      stat_branches <= stat_branches + 32'd1;
      if (EX_BP_taken != EX_true_taken) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  logic unused_bp_taken;
  assign unused_bp_taken  = EX_BP_taken;
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: constant vector table, hand-written corner sequences, random traffic vs a behavioural model.
module tb_branch_predictor;

`ifdef BP_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] F_pc;
  logic        F_BP_taken;
  logic [31:0] F_BP_target;
  logic        EX_upd;
  logic [31:0] EX_pc;
  logic        EX_true_taken;
  logic [31:0] EX_target;
  logic        EX_BP_taken;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int total = 0;
  int bad   = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .F_pc(F_pc), .F_BP_taken(F_BP_taken),
    .F_BP_target(F_BP_target), .EX_upd(EX_upd), .EX_pc(EX_pc),
    .EX_true_taken(EX_true_taken), .EX_target(EX_target), .EX_BP_taken(EX_BP_taken),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Model: each slot remembers the full PC that owns it and a confidence 0..3.
  bit          m_val  [16];
  logic [31:0] m_owner[16];
  int          m_conf [16];
  logic [31:0] m_tgt  [16];
  int          e_br, e_mis;

  function automatic bit m_hit(logic [31:0] pc);
    int s = int'(pc % 16);
    return m_val[s] && ((m_owner[s] / 16) == (pc / 16));
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && (m_conf[int'(pc % 16)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc);
    return m_taken(pc) ? m_tgt[int'(pc % 16)] : pc + 32'd1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_val[i] = 0; m_owner[i] = 0; m_conf[i] = 1; m_tgt[i] = 0;
    end
    e_br = 0; e_mis = 0;
  endtask

  task automatic m_update(logic [31:0] pc, bit tk, logic [31:0] tgt, bit bp);
    int s = int'(pc % 16);
    if (m_hit(pc)) begin
      if (tk) begin
        m_conf[s] = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
        m_tgt[s]  = tgt;
      end else begin
        m_conf[s] = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
      end
    end else if (tk) begin
      m_val[s] = 1; m_owner[s] = pc; m_conf[s] = 2; m_tgt[s] = tgt;
    end
    e_br++;
    if (bp != tk) e_mis++;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_stats(string name);
    check({name, ".branches"},    stat_branches,    STATS_ON ? 32'(e_br)  : 32'd0);
    check({name, ".mispredicts"}, stat_mispredicts, STATS_ON ? 32'(e_mis) : 32'd0);
  endtask

  // Drive one resolution, take one edge, mirror it into the model.
  task automatic edge_upd(bit upd, logic [31:0] pc, bit tk, logic [31:0] tgt, bit bp);
    EX_upd = upd; EX_pc = pc; EX_true_taken = tk; EX_target = tgt; EX_BP_taken = bp;
    @(posedge clk);
    if (upd) m_update(pc, tk, tgt, bp);
    #1;
    EX_upd = 1'b0;
  endtask

  task automatic look(string name, logic [31:0] pc, bit e_tk, logic [31:0] e_tgt);
    F_pc = pc;
    #1;
    check({name, ".taken"},  {31'd0, F_BP_taken}, {31'd0, e_tk});
    check({name, ".target"}, F_BP_target, e_tgt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          upd;
    logic [31:0] pc;
    bit          tk;
    logic [31:0] tgt;
    bit          bp;
    logic [31:0] lpc;
    bit          e_tk;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{0, 32'h00, 0, 32'h00, 0, 32'h24,       0, 32'h25};
    vecs[1]  = '{0, 32'h00, 0, 32'h00, 0, 32'hFFFFFFFF, 0, 32'h00};
    vecs[2]  = '{1, 32'h24, 1, 32'h10, 0, 32'h24,       1, 32'h10};
    vecs[3]  = '{1, 32'h24, 0, 32'h10, 1, 32'h24,       0, 32'h25};
    vecs[4]  = '{1, 32'h24, 0, 32'h10, 0, 32'h24,       0, 32'h25};
    vecs[5]  = '{1, 32'h24, 1, 32'h10, 0, 32'h24,       0, 32'h25};
    vecs[6]  = '{1, 32'h24, 1, 32'h10, 0, 32'h24,       1, 32'h10};
    vecs[7]  = '{1, 32'h24, 1, 32'h10, 1, 32'h24,       1, 32'h10};
    vecs[8]  = '{1, 32'h24, 1, 32'h10, 1, 32'h24,       1, 32'h10};
    vecs[9]  = '{1, 32'h24, 0, 32'h10, 1, 32'h24,       1, 32'h10};
    vecs[10] = '{1, 32'h55, 0, 32'h99, 0, 32'h55,       0, 32'h56};
    vecs[11] = '{1, 32'h34, 1, 32'h40, 0, 32'h24,       0, 32'h25};
    vecs[12] = '{0, 32'h00, 0, 32'h00, 0, 32'h34,       1, 32'h40};
    vecs[13] = '{1, 32'h34, 1, 32'h77, 1, 32'h34,       1, 32'h77};

    rst_n = 1'b0; F_pc = 32'h24; EX_upd = 0; EX_pc = 0; EX_true_taken = 0;
    EX_target = 0; EX_BP_taken = 0;
    m_reset();
    #2;
    check("reset.taken",  {31'd0, F_BP_taken}, 32'd0);
    check("reset.target", F_BP_target, 32'h25);
    check_stats("reset");
    #5 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].upd) edge_upd(1, vecs[i].pc, vecs[i].tk, vecs[i].tgt, vecs[i].bp);
      else             edge_upd(0, 0, 0, 0, 0);
      look($sformatf("vec%0d", i), vecs[i].lpc, vecs[i].e_tk, vecs[i].e_tgt);
    end
    check_stats("vec");

    // Same-cycle lookup of the slot being allocated sees the old contents.
    @(negedge clk);
    EX_upd = 1; EX_pc = 32'h39; EX_true_taken = 1; EX_target = 32'h05; EX_BP_taken = 0;
    look("same.before", 32'h39, 0, 32'h3A);
    @(posedge clk);
    m_update(32'h39, 1, 32'h05, 0);
    #1 EX_upd = 0;
    look("same.after", 32'h39, 1, 32'h05);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, lpc;
      bit upd, tk, bp;
      pc  = 32'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
      if (pc >= 32'h30) pc = 32'hFFFFFFF0 | pc;
      lpc = 32'($urandom_range(0, 2) * 16 + $urandom_range(0, 15));
      if (lpc >= 32'h20) lpc = 32'hFFFFFFF0 | lpc;
      upd = ($urandom_range(0, 3) != 0);
      tk  = $urandom_range(0, 1) == 1;
      bp  = $urandom_range(0, 1) == 1;
      @(negedge clk);
      EX_upd = upd; EX_pc = pc; EX_true_taken = tk; EX_target = $urandom; EX_BP_taken = bp;
      F_pc = lpc;
      #1;
      if (n % 8 == 0 || F_BP_taken !== m_taken(lpc) || F_BP_target !== m_target(lpc)) begin
        check("rand.taken",  {31'd0, F_BP_taken}, {31'd0, m_taken(lpc)});
        check("rand.target", F_BP_target, m_target(lpc));
      end
      @(posedge clk);
      if (upd) m_update(pc, tk, EX_target, bp);
      #1 EX_upd = 0;
    end
    check_stats("rand");

    // Five resolutions, two of them carrying a wrong direction.
    do_reset();
    edge_upd(1, 32'h24, 1, 32'h10, 1);
    edge_upd(1, 32'h24, 0, 32'h10, 1);
    edge_upd(1, 32'h34, 0, 32'h10, 0);
    edge_upd(1, 32'h24, 1, 32'h10, 0);
    edge_upd(0, 32'h00, 0, 32'h00, 1);
    edge_upd(1, 32'h24, 1, 32'h10, 1);
    check("stats5.branches",    stat_branches,    STATS_ON ? 32'd5 : 32'd0);
    check("stats5.mispredicts", stat_mispredicts, STATS_ON ? 32'd2 : 32'd0);
    look("stats5.pred", 32'h24, 1, 32'h10);

    // Reset dropped with a taken allocation pending: clears at once, update is lost.
    @(negedge clk);
    EX_upd = 1; EX_pc = 32'h3A; EX_true_taken = 1; EX_target = 32'h66; EX_BP_taken = 0;
    rst_n = 1'b0;
    m_reset();
    look("midrst.old", 32'h24, 0, 32'h25);
    check_stats("midrst");
    @(posedge clk);
    #1 EX_upd = 0;
    rst_n = 1'b1;
    look("midrst.lost", 32'h3A, 0, 32'h3B);
    look("midrst.wrap", 32'hFFFFFFFF, 0, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
